// File: rtl/adc3664_spi_master.sv
// SPI initiator for the ADC3664 3-wire configuration port: one 24-bit frame
// (R/W, 3 reserved, address, data) per request, with SDIO turnaround on reads.
module adc3664_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              SCLK,
    output logic              SEN,
    output logic              SDIO_out,
    output logic              SDIO_oe,
    input  logic              SDIO_in
);

    localparam int FRAME_W  = 4 + ADDR_W + DATA_W;
    localparam int SHIFT_HP = 2 * FRAME_W;
    localparam int TURN_HP  = 2 * (FRAME_W - DATA_W);
    localparam int CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HP_W     = $clog2(SHIFT_HP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("adc3664_spi_master: CLK_DIV must be >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HP_W-1:0]     hp_q, hp_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                sclk_q, sclk_d;
    logic                sen_q, sen_d;
    logic                sdio_out_q, sdio_out_d;
    logic                sdio_oe_q, sdio_oe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                step;
    logic                last_hp;
    logic                end_cycle;
    logic                accept;

    // Outputs are decoded from the next state and registered, so pins never glitch
    // and the registered outputs always match the registered state.
    // NOTE: every variable written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hp_d     = hp_q;
        shift_d  = shift_q;
        rx_d     = rx_q;
        rw_d     = rw_q;
        rdata_d  = rdata_q;

        step = (cnt_q == CNT_LAST);
        case (state_q)
            ST_SETUP: last_hp = 1'b1;
            ST_SHIFT: last_hp = (hp_q == HP_W'(SHIFT_HP - 1));
            ST_HOLD:  last_hp = 1'b1;
            ST_GAP:   last_hp = (hp_q == HP_W'(1));
            default:  last_hp = 1'b0;
        endcase
        end_cycle = (state_q == ST_GAP) && step && last_hp;
        accept    = start && ((state_q == ST_IDLE) || end_cycle);

        if (accept) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
            hp_d    = '0;
            rw_d    = rw;
            shift_d = {rw, 3'b000, addr, (rw ? {DATA_W{1'b0}} : wdata)};
            rx_d    = '0;
        end else if (state_q != ST_IDLE) begin
            cnt_d = step ? '0 : cnt_q + 1'b1;
            if (step) begin
                hp_d = last_hp ? '0 : hp_q + 1'b1;
                if (last_hp) begin
                    case (state_q)
                        ST_SETUP: state_d = ST_SHIFT;
                        ST_SHIFT: state_d = ST_HOLD;
                        ST_HOLD:  state_d = ST_GAP;
                        default:  state_d = ST_IDLE;
                    endcase
                end
                if (state_q == ST_SHIFT) begin
                    // Leaving an odd half-period is a falling edge; leaving an even one a rising edge.
                    if (hp_q[0]) begin
                        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                    end else if (rw_q && (hp_q >= HP_W'(TURN_HP))) begin
                        rx_d = {rx_q[DATA_W-2:0], SDIO_in};
                    end
                end
            end
        end

        sclk_d     = 1'b0;
        sen_d      = 1'b1;
        sdio_out_d = 1'b0;
        sdio_oe_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            ST_SETUP: begin
                sen_d      = 1'b0;
                sdio_oe_d  = 1'b1;
                sdio_out_d = shift_d[FRAME_W-1];
                busy_d     = 1'b1;
            end
            ST_SHIFT: begin
                sen_d      = 1'b0;
                sclk_d     = hp_d[0];
                sdio_out_d = shift_d[FRAME_W-1];
                sdio_oe_d  = !(rw_d && (hp_d >= HP_W'(TURN_HP)));
                busy_d     = 1'b1;
            end
            ST_HOLD: begin
                sen_d  = 1'b0;
                busy_d = 1'b1;
            end
            ST_GAP: begin
                done_d = (hp_d == HP_W'(1)) && (cnt_d == CNT_LAST);
                busy_d = !done_d;
            end
            default: ;
        endcase

        if (done_d && rw_d) begin
            rdata_d = rx_d;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hp_q       <= '0;
            shift_q    <= '0;
            rx_q       <= '0;
            rw_q       <= 1'b0;
            rdata_q    <= '0;
            sclk_q     <= 1'b0;
            sen_q      <= 1'b1;
            sdio_out_q <= 1'b0;
            sdio_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hp_q       <= hp_d;
            shift_q    <= shift_d;
            rx_q       <= rx_d;
            rw_q       <= rw_d;
            rdata_q    <= rdata_d;
            sclk_q     <= sclk_d;
            sen_q      <= sen_d;
            sdio_out_q <= sdio_out_d;
            sdio_oe_q  <= sdio_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign SCLK     = sclk_q;
    assign SEN      = sen_q;
    assign SDIO_out = sdio_out_q;
    assign SDIO_oe  = sdio_oe_q;

endmodule

// File: tb/tb_adc3664_spi_master.sv
// Directed bench for adc3664_spi_master: one instance with CLK_DIV=4 and one with
// CLK_DIV=2 share the inputs; a select picks which one is observed.
module tb_adc3664_spi_master;

    logic       clk = 1'b0;
    logic       Reset;
    logic       start;
    logic       rw;
    logic [11:0] addr;
    logic [7:0] wdata;
    logic       SDIO_in;

    logic       busy_a, done_a, sclk_a, sen_a, out_a, oe_a;
    logic [7:0] rdata_a;
    logic       busy_b, done_b, sclk_b, sen_b, out_b, oe_b;
    logic [7:0] rdata_b;

    logic       sel;
    int         cdiv;
    logic       busy, done, sclk, sen, sdio_out, oe;
    logic [7:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [23:0] bits;
    int rises, falls, oe_fall_at, sen_low, gap, done_n, period, first_rise_n;
    logic first_sen, first_busy, first_oe, done_busy;

    always #5 clk = ~clk;

    adc3664_spi_master #(.CLK_DIV(4)) u_dut_div4 (
        .CLK(clk), .Reset(Reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_a), .done(done_a), .rdata(rdata_a), .SCLK(sclk_a), .SEN(sen_a),
        .SDIO_out(out_a), .SDIO_oe(oe_a), .SDIO_in(SDIO_in)
    );

    adc3664_spi_master #(.CLK_DIV(2)) u_dut_div2 (
        .CLK(clk), .Reset(Reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_b), .done(done_b), .rdata(rdata_b), .SCLK(sclk_b), .SEN(sen_b),
        .SDIO_out(out_b), .SDIO_oe(oe_b), .SDIO_in(SDIO_in)
    );

    assign busy     = sel ? busy_b  : busy_a;
    assign done     = sel ? done_b  : done_a;
    assign rdata    = sel ? rdata_b : rdata_a;
    assign sclk     = sel ? sclk_b  : sclk_a;
    assign sen      = sel ? sen_b   : sen_a;
    assign sdio_out = sel ? out_b   : out_a;
    assign oe       = sel ? oe_b    : oe_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request and step to the sample point just after the accept edge.
    task automatic launch(input logic r, input logic [11:0] a, input logic [7:0] d, input bit hold);
        rw    = r;
        addr  = a;
        wdata = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Follow one frame from the first cycle after accept until done (or abort).
    task automatic watch_frame(input logic r, input logic [7:0] resp, input bit poke, input int abort_rise);
        logic prev_sclk = 1'b0;
        logic prev_oe   = 1'b1;
        bits = '0; rises = 0; falls = 0; oe_fall_at = -1; sen_low = 0; gap = 0;
        done_n = -1; period = 0; first_rise_n = 0; done_busy = 1'b1;
        first_sen = sen; first_busy = busy; first_oe = oe;
        for (int n = 1; n <= 60 * cdiv; n++) begin
            if (sclk && !prev_sclk) begin
                rises++;
                bits = {bits[22:0], sdio_out};
                if (rises == 1) first_rise_n = n;
                if (rises == 2) period = n - first_rise_n;
            end
            if (!sclk && prev_sclk) begin
                falls++;
                if (r && falls >= 16 && falls <= 23) SDIO_in = resp[7 - (falls - 16)];
            end
            if (!oe && prev_oe && oe_fall_at < 0) oe_fall_at = falls;
            prev_sclk = sclk;
            prev_oe   = oe;
            if (!sen) sen_low++;
            else if (sen_low > 0) gap++;
            if (poke) begin
                if (n == 10 || n == 100) begin
                    start = 1'b1; addr = 12'hFFF; wdata = 8'h00; rw = ~r;
                end else begin
                    start = 1'b0;
                end
            end
            if (abort_rise > 0 && rises == abort_rise) begin
                Reset = 1'b1;
                #1;
                check("abort_sen", 32'(sen), 1);
                check("abort_sclk", 32'(sclk), 0);
                check("abort_oe", 32'(oe), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_done", 32'(done), 0);
                return;
            end
            if (done) begin
                done_n    = n;
                done_busy = busy;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("frame_timeout", 1, 0);
    endtask

    task automatic frame_checks(input string tg, input logic r, input logic [11:0] a, input logic [7:0] d);
        if (r) check({tg, "_hdr16"}, 32'(bits[23:8]), 32'({1'b1, 3'b000, a}));
        else   check({tg, "_bits"}, 32'(bits), 32'({1'b0, 3'b000, a, d}));
        check({tg, "_rises"}, rises, 24);
        check({tg, "_done_cyc"}, done_n, 52 * cdiv);
        check({tg, "_done_busy"}, 32'(done_busy), 0);
        check({tg, "_oe_fall"}, oe_fall_at, r ? 16 : 24);
        check({tg, "_sen_low"}, sen_low, 50 * cdiv);
        check({tg, "_gap"}, gap, 2 * cdiv);
        check({tg, "_first_sen"}, 32'(first_sen), 0);
        check({tg, "_first_busy"}, 32'(first_busy), 1);
        check({tg, "_first_oe"}, 32'(first_oe), 1);
        check({tg, "_sclk_per"}, period, 2 * cdiv);
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic t1_t2(input string pfx);
        launch(1'b0, 12'h123, 8'hA5, 1'b0);
        watch_frame(1'b0, 8'h00, 1'b0, 0);
        frame_checks({pfx, "t1"}, 1'b0, 12'h123, 8'hA5);
        check({pfx, "t1_rdata"}, 32'(rdata), 0);
        wait_cycles(3);

        launch(1'b1, 12'h0FF, 8'hEE, 1'b0);
        watch_frame(1'b1, 8'h3C, 1'b0, 0);
        frame_checks({pfx, "t2"}, 1'b1, 12'h0FF, 8'hEE);
        check({pfx, "t2_rdata_done"}, 32'(rdata), 32'h3C);
        wait_cycles(10);
        check({pfx, "t2_rdata_held"}, 32'(rdata), 32'h3C);
    endtask

    initial begin
        int extra_done;
        Reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; SDIO_in = 1'b0;
        sel = 1'b0; cdiv = 4;
        wait_cycles(3);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_sen", 32'(sen), 1);
        check("rst_out", 32'(sdio_out), 0);
        check("rst_oe", 32'(oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rdata", 32'(rdata), 0);
        Reset = 1'b0;
        wait_cycles(2);

        t1_t2("d4_");

        // Requests during a frame must not disturb it or queue another one.
        launch(1'b0, 12'h456, 8'h5A, 1'b0);
        watch_frame(1'b0, 8'h00, 1'b1, 0);
        frame_checks("t3", 1'b0, 12'h456, 8'h5A);
        extra_done = 0;
        for (int i = 0; i < 30 * cdiv; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check("t3_extra_done", extra_done, 0);
        check("t3_idle_busy", 32'(busy), 0);
        check("t3_rdata_kept", 32'(rdata), 32'h3C);

        // Reset in the middle of a write.
        launch(1'b0, 12'h321, 8'h77, 1'b0);
        watch_frame(1'b0, 8'h00, 1'b0, 10);
        extra_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check("t4_no_done", extra_done, 0);
        check("t4_rdata_clr", 32'(rdata), 0);
        Reset = 1'b0;
        wait_cycles(2);
        launch(1'b0, 12'h2AB, 8'hC3, 1'b0);
        watch_frame(1'b0, 8'h00, 1'b0, 0);
        frame_checks("t4_after", 1'b0, 12'h2AB, 8'hC3);
        wait_cycles(3);

        // start held high: the read is accepted in the write's done cycle.
        launch(1'b0, 12'h1E0, 8'h81, 1'b1);
        watch_frame(1'b0, 8'h00, 1'b0, 0);
        frame_checks("t5_wr", 1'b0, 12'h1E0, 8'h81);
        rw = 1'b1; addr = 12'h07F; wdata = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        watch_frame(1'b1, 8'h96, 1'b0, 0);
        frame_checks("t5_rd", 1'b1, 12'h07F, 8'h00);
        check("t5_rdata", 32'(rdata), 32'h96);
        wait_cycles(3);

        // Same write and read on the CLK_DIV=2 instance.
        Reset = 1'b1;
        sel = 1'b1; cdiv = 2;
        wait_cycles(2);
        Reset = 1'b0;
        wait_cycles(2);
        t1_t2("d2_");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
